// File: rtl/regfile_move_ctrl.sv
// Command controller for a 4x16 register file: LOAD, MOVE, SWAP and CLEAR
// sequenced by a single FSM with registered outputs and a reset-gated write strobe.
module regfile_move_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_a,
    input  logic [2:0]        cmd_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              rf_w,
    output logic [2:0]        rf_wa,
    output logic [2:0]        rf_raA,
    output logic [2:0]        rf_raB,
    output logic [DATA_W-1:0] rf_wd,
    input  logic [DATA_W-1:0] rf_rdA,
    input  logic [DATA_W-1:0] rf_rdB
);

    typedef enum logic [2:0] {IDLE, RD, WR1, WR2, CLR, DONE, ERR} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t            state;
    logic [1:0]        op_q;
    logic [2:0]        a_q;
    logic [2:0]        b_q;
    logic [DATA_W-1:0] tmp_a;
    logic [DATA_W-1:0] tmp_b;
    logic [1:0]        cnt;

    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              rfw_q;
    logic [2:0]        wa_q;
    logic [2:0]        raa_q;
    logic [2:0]        rab_q;
    logic [DATA_W-1:0] wd_q;

    // Only addresses 0-3 exist; which operands are checked depends on the op.
    function automatic logic addr_ok(input logic [1:0] op, input logic [2:0] a,
                                     input logic [2:0] b);
        case (op)
            OP_LOAD:          addr_ok = !a[2];
            OP_MOVE, OP_SWAP: addr_ok = !a[2] && !b[2];
            default:          addr_ok = 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tmp_a   <= '0;
            tmp_b   <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rfw_q   <= 1'b0;
            wa_q    <= '0;
            raa_q   <= '0;
            rab_q   <= '0;
            wd_q    <= '0;
        end else begin
            // Outputs describe the state being entered; anything not driven there is zero.
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rfw_q   <= 1'b0;
            wa_q    <= '0;
            raa_q   <= '0;
            rab_q   <= '0;
            wd_q    <= '0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!addr_ok(cmd_op, cmd_a, cmd_b)) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_LOAD: begin
                                    state <= WR1;
                                    rfw_q <= 1'b1;
                                    wa_q  <= cmd_a;
                                    wd_q  <= cmd_data;
                                end
                                OP_MOVE, OP_SWAP: begin
                                    state <= RD;
                                    raa_q <= cmd_a;
                                    rab_q <= cmd_b;
                                end
                                default: begin
                                    state <= CLR;
                                    cnt   <= 2'd0;
                                    rfw_q <= 1'b1;
                                    wa_q  <= 3'd0;
                                end
                            endcase
                        end
                    end
                end
                RD: begin
                    // Read data is combinational from raA/raB, so it is valid this cycle.
                    tmp_a <= rf_rdA;
                    tmp_b <= rf_rdB;
                    state <= WR1;
                    rfw_q <= 1'b1;
                    wa_q  <= b_q;
                    wd_q  <= rf_rdA;
                end
                WR1: begin
                    if (op_q == OP_SWAP) begin
                        state <= WR2;
                        rfw_q <= 1'b1;
                        wa_q  <= a_q;
                        wd_q  <= tmp_b;
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                WR2: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                CLR: begin
                    if (cnt == 2'd3) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt   <= cnt + 2'd1;
                        rfw_q <= 1'b1;
                        wa_q  <= {1'b0, cnt + 2'd1};
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Reset forces reset-valued outputs immediately, so no write lands on a reset edge.
    assign cmd_ready = ready_q | rst;
    assign busy      = busy_q & ~rst;
    assign done      = done_q & ~rst;
    assign err       = err_q & ~rst;
    assign rf_w      = rfw_q & ~rst;
    assign rf_wa     = rst ? 3'd0 : wa_q;
    assign rf_raA    = rst ? 3'd0 : raa_q;
    assign rf_raB    = rst ? 3'd0 : rab_q;
    assign rf_wd     = rst ? '0 : wd_q;

endmodule

// File: tb/tb_regfile_move_ctrl.sv
// Directed bench for regfile_move_ctrl with a behavioural 4x16 register file.
module tb_regfile_move_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_a;
    logic [2:0]  cmd_b;
    logic [15:0] cmd_data;
    logic        done;
    logic        err;
    logic        busy;
    logic        rf_w;
    logic [2:0]  rf_wa;
    logic [2:0]  rf_raA;
    logic [2:0]  rf_raB;
    logic [15:0] rf_wd;
    logic [15:0] rf_rdA;
    logic [15:0] rf_rdB;

    logic [15:0] rf [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    int checks = 0;
    int errors = 0;
    logic [2:0]  wa_log [16];
    logic [15:0] wd_log [16];
    int nw;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_w) rf[rf_wa[1:0]] <= rf_wd;
    end
    assign rf_rdA = rf[rf_raA[1:0]];
    assign rf_rdB = rf[rf_raB[1:0]];

    regfile_move_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
        .done(done), .err(err), .busy(busy), .rf_w(rf_w), .rf_wa(rf_wa),
        .rf_raA(rf_raA), .rf_raB(rf_raB), .rf_wd(rf_wd),
        .rf_rdA(rf_rdA), .rf_rdB(rf_rdB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        check({tag, ".ctl"}, {28'd0, done, err, busy, rf_w}, 32'd0);
        check({tag, ".addr"}, {23'd0, rf_wa, rf_raA, rf_raB}, 32'd0);
        check({tag, ".wd"}, 32'(rf_wd), 32'd0);
    endtask

    // Issue one command and follow it to its done/err pulse.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] a,
                           input logic [2:0] b, input logic [15:0] d, input int exp_cyc,
                           input bit exp_err, input int exp_w);
        int cyc;
        int nbusy;
        bit fin;
        logic [1:0] fin_flags;
        @(negedge clk);
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_a = 3'd7; cmd_b = 3'd6; cmd_data = 16'hDEAD; cmd_op = ~op;
        nw = 0; cyc = 0; nbusy = 0; fin = 1'b0; fin_flags = 2'b00;
        while (!fin && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (rf_w && nw < 16) begin
                wa_log[nw] = rf_wa;
                wd_log[nw] = rf_wd;
                nw++;
            end
            if (done || err) begin
                fin = 1'b1;
                fin_flags = {done, err};
            end
        end
        check({tag, ".latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".done_err"}, 32'(fin_flags), exp_err ? 32'd1 : 32'd2);
        check({tag, ".writes"}, 32'(nw), 32'(exp_w));
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_cyc));
        @(negedge clk);
        check({tag, ".ready_back"}, {30'd0, cmd_ready, busy}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 3'd0; cmd_b = 3'd0; cmd_data = 16'hFFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("reset.idle_busy", 32'(busy), 32'd0);
        check("reset.no_write", 32'(rf[0]), 32'h1111);

        run_cmd("load0", 2'b00, 3'd0, 3'd0, 16'hAAAA, 2, 1'b0, 1);
        check("load0.wa", 32'(wa_log[0]), 32'd0);
        check("load0.r0", 32'(rf[0]), 32'hAAAA);
        run_cmd("load1", 2'b00, 3'd1, 3'd0, 16'h5555, 2, 1'b0, 1);
        check("load1.r1", 32'(rf[1]), 32'h5555);

        run_cmd("move03", 2'b01, 3'd0, 3'd3, 16'h0, 3, 1'b0, 1);
        check("move03.wa_wd", {13'd0, wa_log[0], wd_log[0]}, {13'd0, 3'd3, 16'hAAAA});
        check("move03.r3", 32'(rf[3]), 32'hAAAA);
        check("move03.r0", 32'(rf[0]), 32'hAAAA);

        run_cmd("swap01", 2'b10, 3'd0, 3'd1, 16'h0, 4, 1'b0, 2);
        check("swap01.r0", 32'(rf[0]), 32'h5555);
        check("swap01.r1", 32'(rf[1]), 32'hAAAA);

        run_cmd("move_bad", 2'b01, 3'd5, 3'd1, 16'h0, 1, 1'b1, 0);
        check("move_bad.regs", {rf[0], rf[1]}, {16'h5555, 16'hAAAA});

        run_cmd("load_bad", 2'b00, 3'd4, 3'd0, 16'h9999, 1, 1'b1, 0);

        run_cmd("swap22", 2'b10, 3'd2, 3'd2, 16'h0, 4, 1'b0, 2);
        check("swap22.r2", 32'(rf[2]), 32'h3333);

        run_cmd("clear", 2'b11, 3'd7, 3'd5, 16'hFFFF, 5, 1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clear.wa%0d", i), 32'(wa_log[i]), 32'(i));
            check($sformatf("clear.wd%0d", i), 32'(wd_log[i]), 32'd0);
            check($sformatf("clear.r%0d", i), 32'(rf[i]), 32'd0);
        end

        run_cmd("load_b_ignored", 2'b00, 3'd2, 3'd7, 16'h1234, 2, 1'b0, 1);
        check("load_b_ignored.r2", 32'(rf[2]), 32'h1234);

        run_cmd("reload0", 2'b00, 3'd0, 3'd0, 16'hAAAA, 2, 1'b0, 1);
        run_cmd("reload1", 2'b00, 3'd1, 3'd0, 16'h5555, 2, 1'b0, 1);

        // SWAP interrupted by reset during WR2
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 3'd0; cmd_b = 3'd1; cmd_data = 16'h0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rswap.rd", {23'd0, rf_w, rf_raA, rf_raB, 2'd0}, {23'd0, 1'b0, 3'd0, 3'd1, 2'd0});
        @(negedge clk);
        check("rswap.wr1", {12'd0, rf_w, rf_wa, rf_wd}, {12'd0, 1'b1, 3'd1, 16'hAAAA});
        @(negedge clk);
        check("rswap.wr2", {12'd0, rf_w, rf_wa, rf_wd}, {12'd0, 1'b1, 3'd0, 16'h5555});
        rst = 1'b1;
        #1;
        check_reset_outputs("rswap.during");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rswap.after");
        @(negedge clk);
        check("rswap.no_done", {30'd0, done, busy}, 32'd0);
        check("rswap.r0", 32'(rf[0]), 32'hAAAA);
        check("rswap.r1", 32'(rf[1]), 32'hAAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
